// File: rtl/bcd_pkg.sv
// Shared types, 7-segment code constants and helpers for the N-digit BCD counter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 8;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Active-high segment codes, bit order g..a
  localparam logic [6:0] SEG_CODE_0 = 7'h3F;
  localparam logic [6:0] SEG_CODE_1 = 7'h06;
  localparam logic [6:0] SEG_CODE_2 = 7'h5B;
  localparam logic [6:0] SEG_CODE_3 = 7'h4F;
  localparam logic [6:0] SEG_CODE_4 = 7'h66;
  localparam logic [6:0] SEG_CODE_5 = 7'h6D;
  localparam logic [6:0] SEG_CODE_6 = 7'h7D;
  localparam logic [6:0] SEG_CODE_7 = 7'h07;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h6F;

  // Active-high blank digit including dp (everything unlit)
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Decode one BCD digit to active-high g..a; non-BCD codes show nothing
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] code;
    code = 7'h00;
    case (d)
      4'd0: code = SEG_CODE_0;
      4'd1: code = SEG_CODE_1;
      4'd2: code = SEG_CODE_2;
      4'd3: code = SEG_CODE_3;
      4'd4: code = SEG_CODE_4;
      4'd5: code = SEG_CODE_5;
      4'd6: code = SEG_CODE_6;
      4'd7: code = SEG_CODE_7;
      4'd8: code = SEG_CODE_8;
      4'd9: code = SEG_CODE_9;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  // Saturate a loaded nibble to a legal BCD digit
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: clear, clamped load, up/down step with carry/borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       up_dn_i,
  input  logic       step_i,
  output bcd_digit_t q_o,
  output bcd_digit_t d_c,
  output logic       carry_c
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  // Next digit value: clear beats load beats step; carry only on a real rollover
  always_comb begin
    q_d     = q_q;
    carry_c = 1'b0;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = bcd_clamp(load_val_i);
    end else if (step_i) begin
      if (up_dn_i) begin
        if (q_q >= 4'd9) begin
          q_d     = 4'd0;
          carry_c = 1'b1;
        end else begin
          q_d = q_q + 4'd1;
        end
      end else begin
        if (q_q == 4'd0) begin
          q_d     = 4'd9;
          carry_c = 1'b1;
        end else begin
          q_d = q_q - 4'd1;
        end
      end
    end
  end

  // Digit register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
  assign d_c = q_d;

endmodule

// File: rtl/bcd_counter_ndig.sv
// N-digit up/down BCD counter with prescaler and registered 7-segment outputs.
// Optional macro BCD_LZ_BLANK_EN blanks leading-zero digits (digit 0 never blanked).
module bcd_counter_ndig
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned CLK_DIV        = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  input  logic                      clr,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic [8*NUM_DIGITS-1:0]   seg,
  output logic                      tick,
  output logic                      wrap
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  // Reset/idle display value: "0" everywhere, or blank above digit 0 when blanking
  function automatic logic [8*NUM_DIGITS-1:0] seg_reset_val();
    logic [8*NUM_DIGITS-1:0] v;
    logic [SEG_W-1:0]        b;
    v = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      b = {1'b0, SEG_CODE_0};
`ifdef BCD_LZ_BLANK_EN
      if (i != 0) b = SEG_BLANK;
`endif
      v[8*i +: 8] = SEG_ACTIVE_LOW ? ~b : b;
    end
    return v;
  endfunction

  localparam logic [8*NUM_DIGITS-1:0] SEG_RST = seg_reset_val();

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    tick_en_c;
  logic [NUM_DIGITS:0]     step_c;
  bcd_digit_t              digit_d [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0] seg_d;
  logic [SEG_W-1:0]        seg_byte;
  logic                    lead_zero;
  logic                    tick_q;
  logic                    wrap_q;
  logic [8*NUM_DIGITS-1:0] seg_q;

  // Prescaler: free-runs 0..CLK_DIV-1 while enabled, cleared by clr
  always_comb begin
    cnt_d     = cnt_q;
    tick_en_c = en && (cnt_q == CNT_LAST);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick_en_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // A count step only happens when neither clr nor load owns the cycle
  assign step_c[0] = tick_en_c && !clr && !load;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .load_i     (load),
      .load_val_i (load_val[4*g +: 4]),
      .up_dn_i    (up_dn),
      .step_i     (step_c[g]),
      .q_o        (bcd[4*g +: 4]),
      .d_c        (digit_d[g]),
      .carry_c    (step_c[g+1])
    );
  end

  // Segment codes from the next-state digits so seg and bcd move together
  always_comb begin
    seg_d     = '0;
    seg_byte  = '0;
    lead_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      seg_byte  = {1'b0, seg_decode(digit_d[i])};
      lead_zero = lead_zero && (digit_d[i] == 4'd0);
`ifdef BCD_LZ_BLANK_EN
      if (lead_zero && (i != 0)) seg_byte = SEG_BLANK;
`endif
      seg_d[8*i +: 8] = SEG_ACTIVE_LOW ? ~seg_byte : seg_byte;
    end
  end

  // Prescaler, strobes and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      seg_q  <= SEG_RST;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_en_c && !clr;
      wrap_q <= step_c[NUM_DIGITS];
      seg_q  <= seg_d;
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;
  assign seg  = seg_q;

endmodule
